// File: rtl/boot_ctrl.sv
// boot_ctrl: boots the core out of reset and supervises one program run.
// Sequence: IDLE -> CRST (core reset held) -> FETCH (first-fetch pulse) ->
// RUN (cycle counting) -> DRAIN (clock kept on briefly) -> DONE.
// Optional watchdog: define BOOT_CTRL_WATCHDOG_EN to abort a run that goes
// WATCHDOG_TIM RUN cycles without a wd_kick.
module boot_ctrl #(
   parameter int ADDR_W       = 16,
   parameter int RST_CYCLES   = 10,
   parameter int DRAIN_CYCLES = 2,
   parameter int WATCHDOG_TIM = 50
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] boot_addr,
   input  logic              halt,
   input  logic              wd_kick,
   output logic              core_rstn,
   output logic              core_clk_en,
   output logic [ADDR_W-1:0] first_fetch_addr,
   output logic              first_fetch_trigger,
   output logic              busy,
   output logic              done,
   output logic              timeout,
   output logic [31:0]       cycle_count
);

   typedef enum logic [2:0] {
      IDLE,
      CRST,
      FETCH,
      RUN,
      DRAIN,
      DONE
   } state_t;

   // Phase counters load "length - 1" and count down to zero.
   localparam logic [31:0] RST_LAST   = 32'(RST_CYCLES - 1);
   localparam logic [31:0] DRAIN_LAST = (DRAIN_CYCLES > 0) ? 32'(DRAIN_CYCLES - 1) : 32'd0;

   state_t      state;
   logic [31:0] phase_cnt;

`ifdef BOOT_CTRL_WATCHDOG_EN
   logic [15:0] wd_cnt;
   logic [16:0] wd_next;
   logic        wd_expire;

   // Watchdog expires on the RUN cycle whose count would reach the threshold.
   assign wd_next   = {1'b0, wd_cnt} + 17'd1;
   assign wd_expire = (wd_next >= 17'(WATCHDOG_TIM));
`else
   logic unused_wd_kick;

   // Without the watchdog the kick input has no function and timeout never fires.
   assign unused_wd_kick = wd_kick;
   assign timeout        = 1'b0;
`endif

   // Boot sequencer: state, phase timing, run counter and all registered outputs.
   // NOTE: every register here is assigned with <= so all of them update
   // together from the values present before the clock edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state               <= IDLE;
         phase_cnt           <= '0;
         core_rstn           <= 1'b0;
         core_clk_en         <= 1'b0;
         first_fetch_addr    <= '0;
         first_fetch_trigger <= 1'b0;
         busy                <= 1'b0;
         done                <= 1'b0;
         cycle_count         <= '0;
`ifdef BOOT_CTRL_WATCHDOG_EN
         timeout             <= 1'b0;
         wd_cnt              <= '0;
`endif
      end else begin
         // The fetch trigger is a single-cycle pulse unless FETCH re-arms it.
         first_fetch_trigger <= 1'b0;

         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state            <= CRST;
                  phase_cnt        <= RST_LAST;
                  first_fetch_addr <= boot_addr;
                  core_rstn        <= 1'b0;
                  core_clk_en      <= 1'b1;
                  busy             <= 1'b1;
                  done             <= 1'b0;
                  cycle_count      <= '0;
`ifdef BOOT_CTRL_WATCHDOG_EN
                  timeout          <= 1'b0;
`endif
               end
            end

            CRST: begin
               if (phase_cnt == 32'd0) begin
                  state               <= FETCH;
                  core_rstn           <= 1'b1;
                  first_fetch_trigger <= 1'b1;
               end else begin
                  phase_cnt <= phase_cnt - 32'd1;
               end
            end

            FETCH: begin
               state <= RUN;
`ifdef BOOT_CTRL_WATCHDOG_EN
               wd_cnt <= '0;
`endif
            end

            RUN: begin
               if (cycle_count != 32'hFFFF_FFFF) begin
                  cycle_count <= cycle_count + 32'd1;
               end
               if (halt) begin
                  if (DRAIN_CYCLES == 0) begin
                     state       <= DONE;
                     core_clk_en <= 1'b0;
                     busy        <= 1'b0;
                     done        <= 1'b1;
                  end else begin
                     state     <= DRAIN;
                     phase_cnt <= DRAIN_LAST;
                  end
               end
`ifdef BOOT_CTRL_WATCHDOG_EN
               // Halt beats expiry, and a kick in the same cycle beats expiry.
               else if (wd_kick) begin
                  wd_cnt <= '0;
               end else if (wd_expire) begin
                  state       <= DONE;
                  core_clk_en <= 1'b0;
                  busy        <= 1'b0;
                  done        <= 1'b1;
                  timeout     <= 1'b1;
               end else begin
                  wd_cnt <= wd_next[15:0];
               end
`endif
            end

            DRAIN: begin
               if (phase_cnt == 32'd0) begin
                  state       <= DONE;
                  core_clk_en <= 1'b0;
                  busy        <= 1'b0;
                  done        <= 1'b1;
               end else begin
                  phase_cnt <= phase_cnt - 32'd1;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_boot_ctrl.sv
// tb_boot_ctrl: self-checking bench for boot_ctrl (default parameters).
// The reference model tracks time since the accepted start and the cycle at
// which RUN ended; every output is derived from those numbers each cycle.
module tb_boot_ctrl;

   localparam int ADDR_W = 16;
   localparam int RST    = 10;
   localparam int DRAIN  = 2;
   localparam int WD     = 50;
`ifdef BOOT_CTRL_WATCHDOG_EN
   localparam bit WD_EN = 1'b1;
`else
   localparam bit WD_EN = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [ADDR_W-1:0] boot_addr;
   logic              halt;
   logic              wd_kick;
   logic              core_rstn;
   logic              core_clk_en;
   logic [ADDR_W-1:0] first_fetch_addr;
   logic              first_fetch_trigger;
   logic              busy;
   logic              done;
   logic              timeout;
   logic [31:0]       cycle_count;

   always #5 clk = ~clk;

   boot_ctrl #(
      .ADDR_W      (ADDR_W),
      .RST_CYCLES  (RST),
      .DRAIN_CYCLES(DRAIN),
      .WATCHDOG_TIM(WD)
   ) dut (
      .clk                (clk),
      .rst                (rst),
      .start              (start),
      .boot_addr          (boot_addr),
      .halt               (halt),
      .wd_kick            (wd_kick),
      .core_rstn          (core_rstn),
      .core_clk_en        (core_clk_en),
      .first_fetch_addr   (first_fetch_addr),
      .first_fetch_trigger(first_fetch_trigger),
      .busy               (busy),
      .done               (done),
      .timeout            (timeout),
      .cycle_count        (cycle_count)
   );

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // t     : cycles elapsed since the accepted start (1 = first cycle after it)
   // end_t : value of t during the last RUN cycle (0 while still running)
   bit              booted = 1'b0;
   int              t      = 0;
   int              end_t  = 0;
   bit              tmo    = 1'b0;
   int              since  = 0;
   logic [ADDR_W-1:0] m_addr = '0;

   function automatic bit m_crst();
      return booted && t >= 1 && t <= RST;
   endfunction

   function automatic bit m_fetch();
      return booted && t == RST + 1;
   endfunction

   function automatic bit m_run();
      return booted && t > RST + 1 && end_t == 0;
   endfunction

   function automatic bit m_drain();
      return booted && end_t != 0 && !tmo && t > end_t && t <= end_t + DRAIN;
   endfunction

   function automatic bit m_done();
      return booted && end_t != 0 && t > end_t + (tmo ? 0 : DRAIN);
   endfunction

   function automatic logic [31:0] m_cnt();
      int lim;
      if (!booted) return 32'd0;
      lim = (end_t != 0) ? end_t : t - 1;
      return (lim > RST + 1) ? 32'(lim - RST - 1) : 32'd0;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         booted <= 1'b0;
         t      <= 0;
         end_t  <= 0;
         tmo    <= 1'b0;
         since  <= 0;
         m_addr <= '0;
      end else if (start && (!booted || m_done())) begin
         booted <= 1'b1;
         t      <= 1;
         end_t  <= 0;
         tmo    <= 1'b0;
         since  <= 0;
         m_addr <= boot_addr;
      end else if (booted && !m_done()) begin
         if (m_run()) begin
            since <= wd_kick ? 0 : since + 1;
            if (halt) begin
               end_t <= t;
            end else if (WD_EN && !wd_kick && since + 1 >= WD) begin
               end_t <= t;
               tmo   <= 1'b1;
            end
         end
         t <= t + 1;
      end
   end

   // Every-cycle comparison of all outputs against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         check("core_rstn",   core_rstn,   booted && !m_crst());
         check("core_clk_en", core_clk_en, m_crst() || m_fetch() || m_run() || m_drain());
         check("busy",        busy,        m_crst() || m_fetch() || m_run() || m_drain());
         check("trigger",     first_fetch_trigger, m_fetch());
         check("ff_addr",     first_fetch_addr, m_addr);
         check("done",        done,        m_done());
         check("timeout",     timeout,     m_done() && tmo);
         check("cycle_count", cycle_count, m_cnt());
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while (!done && n < budget) begin
         step();
         n++;
      end
      check("wait_done", done, 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_time_limit: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int lo;
      int trig;
      rst       = 1'b1;
      start     = 1'b0;
      halt      = 1'b0;
      wd_kick   = 1'b0;
      boot_addr = '0;
      step();
      step();
      chk_en = 1'b1;
      rst    = 1'b0;

      // Reset state, literal.
      check("rst_core_rstn", core_rstn, 0);
      check("rst_clk_en",    core_clk_en, 0);
      check("rst_busy",      busy, 0);
      check("rst_done",      done, 0);
      check("rst_addr",      first_fetch_addr, 0);

      // Boot at 0x0040: 10 reset cycles, one trigger cycle.
      boot_addr = 16'h0040;
      start     = 1'b1;
      step();
      start     = 1'b0;
      boot_addr = 16'($urandom);
      lo   = 0;
      trig = 0;
      for (int i = 0; i < RST + 2; i++) begin
         if (!core_rstn) lo++;
         if (first_fetch_trigger) begin
            trig++;
            check("ffa_at_trigger", first_fetch_addr, 16'h0040);
         end
         check("busy_boot", busy, 1);
         step();
      end
      check("crst_len", lo, RST);
      check("trig_len", trig, 1);

      // Now in RUN cycle 2; halt during RUN cycle 25.
      repeat (23) step();
      halt = 1'b1;
      step();
      halt = 1'b0;
      check("halt_count", cycle_count, 25);
      check("drain1_en",  core_clk_en, 1);
      step();
      check("drain2_en",  core_clk_en, 1);
      check("drain2_cnt", cycle_count, 25);
      step();
      check("done_flag",  done, 1);
      check("done_en",    core_clk_en, 0);
      check("done_rstn",  core_rstn, 1);
      check("done_busy",  busy, 0);

      // Restart from DONE at 0x0100.
      boot_addr = 16'h0100;
      start     = 1'b1;
      step();
      start     = 1'b0;
      check("restart_done", done, 0);
      check("restart_cnt",  cycle_count, 0);
      check("restart_addr", first_fetch_addr, 16'h0100);
      repeat (RST + 6) step();
      // start during RUN must not re-latch.
      boot_addr = 16'hBEEF;
      start     = 1'b1;
      step();
      start     = 1'b0;
      check("ignored_start_addr", first_fetch_addr, 16'h0100);
      check("ignored_start_busy", busy, 1);
      // Reset mid-run.
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("midrst_rstn",  core_rstn, 0);
      check("midrst_en",    core_clk_en, 0);
      check("midrst_trig",  first_fetch_trigger, 0);
      check("midrst_addr",  first_fetch_addr, 0);
      check("midrst_busy",  busy, 0);
      check("midrst_done",  done, 0);
      check("midrst_tmo",   timeout, 0);
      check("midrst_cnt",   cycle_count, 0);

`ifdef BOOT_CTRL_WATCHDOG_EN
      // No kick, no halt: expiry after 50 RUN cycles.
      start = 1'b1;
      step();
      start = 1'b0;
      wait_done(RST + WD + 20);
      check("wd_timeout", timeout, 1);
      check("wd_cnt",     cycle_count, WD);
      check("wd_clk_en",  core_clk_en, 0);
      // Kick every 30 RUN cycles, halt at 120.
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (RST + 1) step();
      for (int k = 1; k <= 120; k++) begin
         wd_kick = (k % 30 == 0);
         halt    = (k == 120);
         step();
      end
      wd_kick = 1'b0;
      halt    = 1'b0;
      check("kick_cnt",     cycle_count, 120);
      check("kick_timeout", timeout, 0);
      wait_done(DRAIN + 4);
      check("kick_done_tmo", timeout, 0);
`else
      // Without the watchdog a long run with random kicks keeps going.
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (RST + 1 + WD + 10) begin
         wd_kick = 1'($urandom_range(0, 1));
         step();
      end
      wd_kick = 1'b0;
      check("nowd_busy",    busy, 1);
      check("nowd_timeout", timeout, 0);
      halt = 1'b1;
      step();
      halt = 1'b0;
      wait_done(DRAIN + 4);
      check("nowd_done_tmo", timeout, 0);
`endif

      // Randomized traffic against the model.
      repeat (3000) begin
         rst       = ($urandom_range(0, 299) == 0);
         start     = ($urandom_range(0, 7) == 0);
         boot_addr = 16'($urandom);
         halt      = ($urandom_range(0, 29) == 0);
         wd_kick   = ($urandom_range(0, 24) == 0);
         step();
      end
      rst     = 1'b0;
      start   = 1'b0;
      halt    = 1'b0;
      wd_kick = 1'b0;
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
